// File: rtl/pipe_ctrl_if.sv
// Control bundle between the 5-stage datapath and the hazard/sequencing controller.
// The datapath side is the master; pipe_ctrl takes the slave view.
interface pipe_ctrl_if;
  logic        imem_ready;
  logic        mem_req;
  logic        dmem_ready;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        dec_use_rs1;
  logic        dec_use_rs2;
  logic [4:0]  exe_rd;
  logic        exe_is_load;
  logic        exe_redirect;
  logic        exe_mdu_start;
  logic        mdu_done;

  logic        regF_stall;
  logic        regD_stall;
  logic        regE_stall;
  logic        regM_stall;
  logic        regW_stall;
  logic        regD_bubble;
  logic        regE_bubble;
  logic        regM_bubble;
  logic        regW_bubble;
  logic        redirect_take;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output imem_ready, mem_req, dmem_ready, dec_rs1, dec_rs2, dec_use_rs1,
           dec_use_rs2, exe_rd, exe_is_load, exe_redirect, exe_mdu_start, mdu_done,
    input  regF_stall, regD_stall, regE_stall, regM_stall, regW_stall,
           regD_bubble, regE_bubble, regM_bubble, regW_bubble, redirect_take,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  imem_ready, mem_req, dmem_ready, dec_rs1, dec_rs2, dec_use_rs1,
           dec_use_rs2, exe_rd, exe_is_load, exe_redirect, exe_mdu_start, mdu_done,
    output regF_stall, regD_stall, regE_stall, regM_stall, regW_stall,
           regD_bubble, regE_bubble, regM_bubble, regW_bubble, redirect_take,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: prioritised stall/bubble
// generation, mul/div wait tracking, stale-fetch discard and stall/flush counters.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic {RUN, MDU_WAIT} state_t;
  typedef enum logic [2:0] {
    HZ_NONE, HZ_IFETCH, HZ_LOADUSE, HZ_REDIRECT, HZ_MDU, HZ_DMEM
  } hazard_t;

  state_t      state_q, state_d;
  logic        pending_q, pending_d;
  logic [31:0] stall_cnt_q, flush_cnt_q;

  logic    dmem_haz;
  logic    mdu_haz;
  logic    load_use;
  logic    ifetch_haz;
  hazard_t hz;

  always_comb begin
    dmem_haz   = bus.mem_req & ~bus.dmem_ready;
    mdu_haz    = ~bus.mdu_done & ((state_q == MDU_WAIT) | bus.exe_mdu_start);
    load_use   = bus.exe_is_load & (bus.exe_rd != 5'd0) &
                 ((bus.dec_use_rs1 & (bus.dec_rs1 == bus.exe_rd)) |
                  (bus.dec_use_rs2 & (bus.dec_rs2 == bus.exe_rd)));
    ifetch_haz = ~bus.imem_ready | pending_q;

    if (dmem_haz)              hz = HZ_DMEM;
    else if (mdu_haz)          hz = HZ_MDU;
    else if (bus.exe_redirect) hz = HZ_REDIRECT;
    else if (load_use)         hz = HZ_LOADUSE;
    else if (ifetch_haz)       hz = HZ_IFETCH;
    else                       hz = HZ_NONE;
  end

  // Only the winning class drives the controls, so stall and bubble never meet on one register.
  always_comb begin
    bus.regF_stall    = 1'b0;
    bus.regD_stall    = 1'b0;
    bus.regE_stall    = 1'b0;
    bus.regM_stall    = 1'b0;
    bus.regW_stall    = 1'b0;
    bus.regD_bubble   = 1'b0;
    bus.regE_bubble   = 1'b0;
    bus.regM_bubble   = 1'b0;
    bus.regW_bubble   = 1'b0;
    bus.redirect_take = 1'b0;

    if (rst) begin
      bus.regD_bubble = 1'b1;
      bus.regE_bubble = 1'b1;
      bus.regM_bubble = 1'b1;
      bus.regW_bubble = 1'b1;
    end else begin
      unique case (hz)
        HZ_DMEM: begin
          bus.regF_stall  = 1'b1;
          bus.regD_stall  = 1'b1;
          bus.regE_stall  = 1'b1;
          bus.regM_stall  = 1'b1;
          bus.regW_bubble = 1'b1;
        end
        HZ_MDU: begin
          bus.regF_stall  = 1'b1;
          bus.regD_stall  = 1'b1;
          bus.regE_stall  = 1'b1;
          bus.regM_bubble = 1'b1;
        end
        HZ_REDIRECT: begin
          bus.regD_bubble   = 1'b1;
          bus.regE_bubble   = 1'b1;
          bus.redirect_take = 1'b1;
        end
        HZ_LOADUSE: begin
          bus.regF_stall  = 1'b1;
          bus.regD_stall  = 1'b1;
          bus.regE_bubble = 1'b1;
        end
        HZ_IFETCH: begin
          bus.regF_stall  = 1'b1;
          bus.regD_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (bus.exe_mdu_start & ~bus.mdu_done & ~dmem_haz) state_d = MDU_WAIT;
      MDU_WAIT: if (bus.mdu_done) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // The stale response is only consumed when the fetch class actually owns the cycle;
  // under a higher hazard D is held and the discard waits.
  always_comb begin
    pending_d = pending_q;
    if (hz == HZ_REDIRECT)
      pending_d = pending_q | ~bus.imem_ready;
    else if ((hz == HZ_IFETCH) && bus.imem_ready)
      pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pending_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_q + {31'd0, bus.regF_stall};
      flush_cnt_q <= flush_cnt_q + {31'd0, bus.redirect_take};
    end
  end

  always_comb begin
    bus.stall_cnt = stall_cnt_q;
    bus.flush_cnt = flush_cnt_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared against a hazard-class reference model.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cycle  = 0;

  // reference model state
  bit          m_busy;
  bit          m_pending;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  localparam int CL_NONE = 0, CL_IF = 1, CL_LU = 2, CL_REDIR = 3,
                 CL_MDU = 4, CL_DMEM = 5, CL_RESET = 6;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got=%h exp=%h", tag, cycle, got, exp);
    end
  endtask

  // Control vector: {F_st, D_st, E_st, M_st, W_st, D_bb, E_bb, M_bb, W_bb, take}
  function automatic logic [9:0] ctl_of(input int cl);
    case (cl)
      CL_DMEM:  return 10'b11110_0001_0;
      CL_MDU:   return 10'b11100_0010_0;
      CL_REDIR: return 10'b00000_1100_1;
      CL_LU:    return 10'b11000_0100_0;
      CL_IF:    return 10'b10000_1000_0;
      CL_RESET: return 10'b00000_1111_0;
      default:  return 10'b00000_0000_0;
    endcase
  endfunction

  function automatic int classify();
    bit lu;
    lu = bus.exe_is_load && bus.exe_rd != 0 &&
         ((bus.dec_use_rs1 && bus.dec_rs1 == bus.exe_rd) ||
          (bus.dec_use_rs2 && bus.dec_rs2 == bus.exe_rd));
    if (rst)                                                return CL_RESET;
    if (bus.mem_req && !bus.dmem_ready)                     return CL_DMEM;
    if (!bus.mdu_done && (m_busy || bus.exe_mdu_start))     return CL_MDU;
    if (bus.exe_redirect)                                   return CL_REDIR;
    if (lu)                                                 return CL_LU;
    if (!bus.imem_ready || m_pending)                       return CL_IF;
    return CL_NONE;
  endfunction

  // Entered just after a negedge with inputs applied; leaves at the following negedge.
  task automatic cyc();
    int         cl;
    logic [9:0] exp, got;
    #1;
    cl  = classify();
    exp = ctl_of(cl);
    got = {bus.regF_stall, bus.regD_stall, bus.regE_stall, bus.regM_stall, bus.regW_stall,
           bus.regD_bubble, bus.regE_bubble, bus.regM_bubble, bus.regW_bubble,
           bus.redirect_take};
    check("ctl", 32'(got), 32'(exp));
    check("stall_cnt", bus.stall_cnt, m_stall);
    check("flush_cnt", bus.flush_cnt, m_flush);
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_pending = 0; m_stall = '0; m_flush = '0;
    end else begin
      if (exp[9]) m_stall = m_stall + 32'd1;
      if (exp[0]) m_flush = m_flush + 32'd1;
      if (cl == CL_REDIR)
        m_pending = m_pending || !bus.imem_ready;
      else if (cl == CL_IF && bus.imem_ready)
        m_pending = 0;
      if (m_busy)
        m_busy = !bus.mdu_done;
      else
        m_busy = bus.exe_mdu_start && !bus.mdu_done && !(bus.mem_req && !bus.dmem_ready);
    end
    cycle++;
    @(negedge clk);
  endtask

  task automatic idle();
    rst               = 1'b0;
    bus.imem_ready    = 1'b1;
    bus.mem_req       = 1'b0;
    bus.dmem_ready    = 1'b1;
    bus.dec_rs1       = '0;
    bus.dec_rs2       = '0;
    bus.dec_use_rs1   = 1'b0;
    bus.dec_use_rs2   = 1'b0;
    bus.exe_rd        = '0;
    bus.exe_is_load   = 1'b0;
    bus.exe_redirect  = 1'b0;
    bus.exe_mdu_start = 1'b0;
    bus.mdu_done      = 1'b0;
  endtask

  initial begin
    m_busy = 0; m_pending = 0; m_stall = '0; m_flush = '0;
    rst = 1'b1;
    bus.imem_ready = 1'b1; bus.mem_req = 1'b1; bus.dmem_ready = 1'b1;
    bus.dec_rs1 = '1; bus.dec_rs2 = '1; bus.dec_use_rs1 = 1'b1; bus.dec_use_rs2 = 1'b1;
    bus.exe_rd = '1; bus.exe_is_load = 1'b1; bus.exe_redirect = 1'b1;
    bus.exe_mdu_start = 1'b1; bus.mdu_done = 1'b1;
    @(negedge clk);
    repeat (2) cyc();

    // load-use on rs2, then the same pattern against x0
    idle();
    cyc();
    bus.exe_is_load = 1'b1; bus.exe_rd = 5'd5; bus.dec_rs2 = 5'd5; bus.dec_use_rs2 = 1'b1;
    cyc();
    idle();
    cyc();
    bus.exe_is_load = 1'b1; bus.exe_rd = 5'd0; bus.dec_rs2 = 5'd0; bus.dec_use_rs2 = 1'b1;
    cyc();

    // mul/div: four stalled cycles then the done cycle runs free
    idle();
    bus.exe_mdu_start = 1'b1;
    repeat (4) cyc();
    bus.mdu_done = 1'b1;
    cyc();
    idle();
    cyc();
    // start and done together never stall
    bus.exe_mdu_start = 1'b1; bus.mdu_done = 1'b1;
    cyc();

    // redirect while fetch is waiting, then stale-fetch discard
    idle();
    bus.exe_redirect = 1'b1; bus.imem_ready = 1'b0;
    cyc();
    bus.exe_redirect = 1'b0;
    repeat (2) cyc();
    bus.imem_ready = 1'b1;
    cyc();
    cyc();

    // everything at once: DMEM wins, redirect suppressed
    bus.mem_req = 1'b1; bus.dmem_ready = 1'b0; bus.exe_redirect = 1'b1;
    bus.exe_is_load = 1'b1; bus.exe_rd = 5'd7; bus.dec_rs1 = 5'd7; bus.dec_use_rs1 = 1'b1;
    cyc();
    idle();

    // DMEM during MDU_WAIT with the done pulse landing under it
    bus.exe_mdu_start = 1'b1;
    repeat (2) cyc();
    bus.mem_req = 1'b1; bus.dmem_ready = 1'b0; bus.mdu_done = 1'b1;
    cyc();
    bus.mem_req = 1'b0; bus.dmem_ready = 1'b1; bus.mdu_done = 1'b0; bus.exe_mdu_start = 1'b0;
    cyc();

    // reset abandons an MDU wait and a pending discard
    bus.exe_redirect = 1'b1; bus.imem_ready = 1'b0;
    cyc();
    bus.exe_redirect = 1'b0; bus.exe_mdu_start = 1'b1;
    cyc();
    rst = 1'b1;
    cyc();
    idle();
    cyc();

    for (int unsigned i = 0; i < 4000; i++) begin
      rst               = ($urandom_range(0, 249) == 0);
      bus.imem_ready    = ($urandom_range(0, 3) != 0);
      bus.mem_req       = ($urandom_range(0, 2) == 0);
      bus.dmem_ready    = ($urandom_range(0, 1) == 0);
      bus.dec_rs1       = 5'($urandom_range(0, 3));
      bus.dec_rs2       = 5'($urandom_range(0, 3));
      bus.dec_use_rs1   = ($urandom_range(0, 1) == 0);
      bus.dec_use_rs2   = ($urandom_range(0, 1) == 0);
      bus.exe_rd        = 5'($urandom_range(0, 3));
      bus.exe_is_load   = ($urandom_range(0, 2) == 0);
      bus.exe_redirect  = ($urandom_range(0, 4) == 0);
      bus.exe_mdu_start = m_busy || ($urandom_range(0, 7) == 0);
      bus.mdu_done      = ($urandom_range(0, 4) == 0);
      cyc();
    end

    idle();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
